// File: rtl/spell_mem_router_pkg.sv
// ============================================================================
//  Module  : spell_mem_pkg
//  Brief   : Shared types and default constants for the spell memory router.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spell_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WAIT_IO  = 2'd2,
    RESP     = 2'd3
  } state_e;

  typedef enum logic {
    TGT_MEM = 1'b0,
    TGT_IO  = 1'b1
  } target_e;

  localparam logic [7:0] IO_BASE_DEF        = 8'h20;
  localparam logic [7:0] IO_LIMIT_DEF       = 8'h60;
  localparam int         TIMEOUT_CYCLES_DEF = 16;
  // Fill bit replicated to DATA_W to build the all-ones error word.
  localparam logic       ERR_FILL           = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spell_mem_router_if.sv
// ============================================================================
//  Module  : spell_mem_router_if
//  Brief   : CPU-side request/response bundle of the spell memory router.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spell_mem_router_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              select;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              memory_type_data;
  logic              write;
  logic [DATA_W-1:0] data_out;
  logic              data_ready;
  logic              bus_error;

  modport master (
    output select, addr, data_in, memory_type_data, write,
    input  data_out, data_ready, bus_error
  );

  modport slave (
    input  select, addr, data_in, memory_type_data, write,
    output data_out, data_ready, bus_error
  );
endinterface

`default_nettype wire

// File: rtl/spell_mem_decode.sv
// ============================================================================
//  Module  : spell_mem_decode
//  Brief   : Combinational address/space decoder selecting MEM or IO target.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spell_mem_decode
  import spell_mem_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(IO_BASE_DEF),
  parameter logic [ADDR_W-1:0] IO_LIMIT = ADDR_W'(IO_LIMIT_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              memory_type_data,
  output target_e           target
);

  always_comb begin
    target = TGT_MEM;
    if (memory_type_data && (addr >= IO_BASE) && (addr < IO_LIMIT))
      target = TGT_IO;
  end

endmodule

`default_nettype wire

// File: rtl/spell_mem_router.sv
// ============================================================================
//  Module  : spell_mem_router
//  Brief   : Registered CPU memory router; latches one access and steers it to
//            the internal memory or the IO window. Optional bus timeout is
//            enabled by defining SPELL_MEM_ROUTER_TIMEOUT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spell_mem_router
  import spell_mem_pkg::*;
#(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 8,
  parameter logic [ADDR_W-1:0] IO_BASE        = ADDR_W'(IO_BASE_DEF),
  parameter logic [ADDR_W-1:0] IO_LIMIT       = ADDR_W'(IO_LIMIT_DEF),
  parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA       = {DATA_W{ERR_FILL}}
) (
  input  logic                clk,
  input  logic                rst_n,
  spell_mem_router_if.slave   cpu,
  output logic                mem_select,
  output logic                mem_write,
  output logic                mem_type_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                io_select,
  output logic                io_write,
  output logic [ADDR_W-1:0]   io_addr,
  output logic [DATA_W-1:0]   io_wdata,
  input  logic [DATA_W-1:0]   io_rdata,
  input  logic                io_ready
);

  state_e            state_q, state_d;
  target_e           tgt_dec;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              type_q, type_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_ready_q, data_ready_d;
  logic              mem_sel_q, mem_sel_d;
  logic              io_sel_q, io_sel_d;
  logic              tgt_ready;
  logic [DATA_W-1:0] tgt_rdata;
`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              bus_error_q, bus_error_d;
`else
  logic              unused_cfg;
  assign unused_cfg = ^{ERR_DATA, 8'(TIMEOUT_CYCLES)};
`endif

  spell_mem_decode #(
    .ADDR_W   (ADDR_W),
    .IO_BASE  (IO_BASE),
    .IO_LIMIT (IO_LIMIT)
  ) u_decode (
    .addr             (cpu.addr),
    .memory_type_data (cpu.memory_type_data),
    .target           (tgt_dec)
  );

  // Ready/data of the non-selected target never reach the FSM.
  assign tgt_ready = (state_q == WAIT_IO) ? io_ready : mem_ready;
  assign tgt_rdata = (state_q == WAIT_IO) ? io_rdata : mem_rdata;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    type_d       = type_q;
    data_out_d   = data_out_q;
    data_ready_d = 1'b0;
    mem_sel_d    = mem_sel_q;
    io_sel_d     = io_sel_q;
`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_error_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cpu.select) begin
          addr_d    = cpu.addr;
          wdata_d   = cpu.data_in;
          write_d   = cpu.write;
          type_d    = cpu.memory_type_data;
          mem_sel_d = (tgt_dec == TGT_MEM);
          io_sel_d  = (tgt_dec == TGT_IO);
          state_d   = (tgt_dec == TGT_IO) ? WAIT_IO : WAIT_MEM;
`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end
      end
      WAIT_MEM, WAIT_IO: begin
        if (tgt_ready) begin
          if (!write_q) data_out_d = tgt_rdata;
          mem_sel_d    = 1'b0;
          io_sel_d     = 1'b0;
          data_ready_d = 1'b1;
          state_d      = RESP;
        end
`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
          if (!write_q) data_out_d = ERR_DATA;
          mem_sel_d    = 1'b0;
          io_sel_d     = 1'b0;
          data_ready_d = 1'b1;
          bus_error_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      type_q       <= 1'b0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      mem_sel_q    <= 1'b0;
      io_sel_q     <= 1'b0;
`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
      cnt_q        <= 8'd0;
      bus_error_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      type_q       <= type_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      mem_sel_q    <= mem_sel_d;
      io_sel_q     <= io_sel_d;
`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
      cnt_q        <= cnt_d;
      bus_error_q  <= bus_error_d;
`endif
    end
  end

  assign cpu.data_out   = data_out_q;
  assign cpu.data_ready = data_ready_q;
`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
  assign cpu.bus_error  = bus_error_q;
`else
  assign cpu.bus_error  = 1'b0;
`endif

  assign mem_select    = mem_sel_q;
  assign mem_write     = write_q;
  assign mem_type_data = type_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign io_select     = io_sel_q;
  assign io_write      = write_q;
  assign io_addr       = addr_q;
  assign io_wdata      = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_spell_mem_router.sv
// ============================================================================
//  Module  : tb_spell_mem_router
//  Brief   : Self-checking bench for spell_mem_router (directed + random).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spell_mem_router;

`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_select, mem_write, mem_type_data;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ready;
  logic       io_select, io_write;
  logic [7:0] io_addr, io_wdata, io_rdata;
  logic       io_ready;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_dout = 8'h00;

  spell_mem_router_if #(.ADDR_W(8), .DATA_W(8)) cpu ();

  spell_mem_router #(
    .ADDR_W         (8),
    .DATA_W         (8),
    .IO_BASE        (8'h20),
    .IO_LIMIT       (8'h60),
    .TIMEOUT_CYCLES (TO),
    .ERR_DATA       (8'hFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu           (cpu.slave),
    .mem_select    (mem_select),
    .mem_write     (mem_write),
    .mem_type_data (mem_type_data),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .io_select     (io_select),
    .io_write      (io_write),
    .io_addr       (io_addr),
    .io_wdata      (io_wdata),
    .io_rdata      (io_rdata),
    .io_ready      (io_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One CPU access; entered and left at #1 after a rising edge in IDLE.
  // waitc < 0 means the target never answers (timeout build only).
  task automatic access(input logic [7:0] a, input logic [7:0] d, input logic t,
                        input logic w, input int waitc, input logic [7:0] rd,
                        input bit drop_early, input bit hold_after);
    bit to_io;
    int k;
    int n;
    int exp_lat;
    bit done;
    to_io   = t && (a >= 8'h20) && (a < 8'h60);
    k       = waitc + 1;
    exp_lat = (waitc < 0) ? TO + 2 : waitc + 2;
    cpu.select = 1'b1; cpu.addr = a; cpu.data_in = d;
    cpu.memory_type_data = t; cpu.write = w;
    @(posedge clk); #1;
    n = 1;
    done = 1'b0;
    check("tgt_sel", 32'({mem_select, io_select}), to_io ? 32'h1 : 32'h2);
    if (to_io)
      check("io_req", 32'({io_addr, io_wdata, io_write}), 32'({a, d, w}));
    else
      check("mem_req", 32'({mem_addr, mem_wdata, mem_write, mem_type_data}), 32'({a, d, w, t}));
    cpu.addr = 8'($urandom); cpu.data_in = 8'($urandom);
    cpu.memory_type_data = 1'($urandom); cpu.write = 1'($urandom);
    if (drop_early) cpu.select = 1'b0;
    while (!done && n < 40) begin
      mem_rdata = to_io ? 8'($urandom) : rd;
      io_rdata  = to_io ? rd : 8'($urandom);
      mem_ready = to_io ? 1'($urandom) : (n == k);
      io_ready  = to_io ? (n == k) : 1'($urandom);
      @(posedge clk); #1;
      n++;
      if (cpu.data_ready === 1'b1) done = 1'b1;
      else if (n < exp_lat)
        check("wait_stable", 32'({mem_select, io_select, mem_addr}), to_io ? 32'({2'b01, a}) : 32'({2'b10, a}));
    end
    mem_ready = 1'b0; io_ready = 1'b0;
    check("done", 32'(done), 32'h1);
    check("latency", 32'(n), 32'(exp_lat));
    if (!w) exp_dout = (waitc < 0) ? 8'hFF : rd;
    check("data_out", 32'(cpu.data_out), 32'(exp_dout));
    check("bus_error", 32'(cpu.bus_error), 32'(waitc < 0));
    check("sel_drop", 32'({mem_select, io_select}), 32'h0);
    if (!hold_after) cpu.select = 1'b0;
    @(posedge clk); #1;
    check("idle", 32'({cpu.data_ready, cpu.bus_error, mem_select, io_select}), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu.select = 1'b0; cpu.addr = 8'h00; cpu.data_in = 8'h00;
    cpu.memory_type_data = 1'b0; cpu.write = 1'b0;
    mem_rdata = 8'h00; mem_ready = 1'b0; io_rdata = 8'h00; io_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ctl", 32'({cpu.data_ready, cpu.bus_error, mem_select, io_select}), 32'h0);
    check("rst_dout", 32'(cpu.data_out), 32'h0);
    check("rst_bus", 32'({mem_addr, mem_wdata, mem_write, mem_type_data, io_addr}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(8'h25, 8'h00, 1'b0, 1'b0, 0, 8'hA5, 1'b0, 1'b0);
    access(8'h30, 8'h5C, 1'b1, 1'b1, 3, 8'h11, 1'b0, 1'b0);
    access(8'h1F, 8'h00, 1'b1, 1'b0, 1, 8'h3C, 1'b0, 1'b0);
    access(8'h20, 8'h00, 1'b1, 1'b0, 0, 8'hC3, 1'b0, 1'b0);
    access(8'h5F, 8'h00, 1'b1, 1'b0, 2, 8'h7E, 1'b0, 1'b0);
    access(8'h60, 8'h00, 1'b1, 1'b0, 0, 8'h81, 1'b0, 1'b0);
    // select held through RESP: next access begins in the following IDLE cycle
    access(8'h40, 8'h00, 1'b1, 1'b0, 1, 8'h5A, 1'b0, 1'b1);
    access(8'h41, 8'h9D, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    access(8'h10, 8'h00, 1'b0, 1'b0, 2, 8'h66, 1'b1, 1'b0);

`ifdef SPELL_MEM_ROUTER_TIMEOUT_EN
    access(8'h30, 8'h00, 1'b1, 1'b0, -1, 8'h00, 1'b0, 1'b0);
    access(8'h31, 8'h00, 1'b1, 1'b0, TO, 8'h2B, 1'b0, 1'b0);
    access(8'h08, 8'h77, 1'b0, 1'b1, -1, 8'h00, 1'b0, 1'b0);
`endif

    // reset while in WAIT_MEM
    cpu.select = 1'b1; cpu.addr = 8'h05; cpu.memory_type_data = 1'b0; cpu.write = 1'b0;
    @(posedge clk); #1;
    check("rw_sel", 32'(mem_select), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rw_ctl", 32'({cpu.data_ready, cpu.bus_error, mem_select, io_select}), 32'h0);
    check("rw_dout", 32'(cpu.data_out), 32'h0);
    check("rw_bus", 32'({mem_addr, mem_wdata, io_addr}), 32'h0);
    exp_dout = 8'h00;
    cpu.select = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rw_no_ready", 32'(cpu.data_ready), 32'h0);
    access(8'h05, 8'h00, 1'b0, 1'b0, 0, 8'hE7, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      access(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 4)), 8'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    cpu.select = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spell_mem_router.md
Name: spell_mem_router

Overview:
- Parametrised, registered successor to the single-cycle combinational memory mux of the spell core.
- Accepts one CPU access at a time and decodes it to either the internal code/data memory target or the IO target (configurable window).
- Latches the request and drives the selected target until it completes, then returns registered read data with a one-cycle data_ready pulse.
- Adds wait-state tolerance and an optional bus timeout.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data width in bits.
- IO_BASE, 8'h20, first data-space address routed to IO (inclusive).
- IO_LIMIT, 8'h60, end of IO window (exclusive); IO_LIMIT > IO_BASE required.
- TIMEOUT_CYCLES, 16, wait cycles before abort (only with timeout feature); range 1..255.
- ERR_DATA, all ones, read data returned on timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- select  in  1  CPU request valid; held until data_ready.
- addr  in  ADDR_W  CPU address.
- data_in  in  DATA_W  CPU write data.
- memory_type_data  in  1  1 = data space, 0 = code space.
- write  in  1  1 = write, 0 = read.
- data_out  out  DATA_W  registered read data.
- data_ready  out  1  one-cycle completion pulse.
- bus_error  out  1  one-cycle pulse coincident with data_ready on timeout.
- mem_select, mem_write, mem_type_data  out  1 each  internal memory request.
- mem_addr  out  ADDR_W  internal memory address.
- mem_wdata  out  DATA_W  internal memory write data.
- mem_rdata  in  DATA_W  internal memory read data.
- mem_ready  in  1  internal memory completion.
- io_select, io_write  out  1 each  IO request.
- io_addr  out  ADDR_W  IO address.
- io_wdata  out  DATA_W  IO write data.
- io_rdata  in  DATA_W  IO read data.
- io_ready  in  1  IO completion.

Behaviour:
- Reset (async, rst_n low): state IDLE; data_out 0; data_ready, bus_error, mem_select and io_select 0; latched address, data and control regs 0.
- Decode: IO when memory_type_data=1 and IO_BASE <= addr < IO_LIMIT (unsigned, ADDR_W-wide compare). All other accesses (all code space, data outside the window) go to MEM.
- State IDLE:
  - On select=1, latch addr, data_in, write, memory_type_data and the decode result.
  - Go to WAIT_MEM or WAIT_IO.
- States WAIT_MEM / WAIT_IO:
  - Target select is driven high from the first cycle in WAIT; addr, wdata and write are driven from the latched regs and stay stable.
  - The other target's select stays 0.
  - Target ready is sampled each cycle. When it is 1: capture rdata into data_out on reads (data_out unchanged on writes), drop target select, go to RESP.
- State RESP:
  - data_ready=1 for exactly one cycle, then IDLE.
  - select is ignored in RESP. The requester must drop select in the cycle it sees data_ready. select still high in the following IDLE cycle starts a new access.
- Latency: request accepted at cycle 0, target select at cycle 1. Ready at cycle k (k>=1) gives data_ready at k+1. Minimum is 2 cycles.
- select dropping mid-WAIT: the access still completes (writes cannot be aborted) and data_ready still pulses.
- Inputs change during WAIT: no effect, because all outputs come from latched values.
- Reset mid-WAIT: target select drops asynchronously and no data_ready is issued.
- Ready from the non-selected target: ignored.

Optional Feature:
- Macro SPELL_MEM_ROUTER_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter clears on WAIT entry and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without ready, the target select drops, data_out is loaded with ERR_DATA (on reads only), and the FSM goes to RESP.
  - In that RESP cycle data_ready and bus_error are both 1.
  - Ready arriving in the same cycle as the timeout wins: normal completion, no bus_error.
- When undefined: no counter, WAIT lasts indefinitely, bus_error tied 0.

Decomposition:
- Package spell_mem_pkg holds:
  - the state enum (IDLE, WAIT_MEM, WAIT_IO, RESP);
  - the target enum (TGT_MEM, TGT_IO);
  - the default constants for IO_BASE, IO_LIMIT, TIMEOUT_CYCLES and ERR_DATA.
- One sub-module, spell_mem_decode: a pure combinational address/type decoder returning the target. It is reused by the future DMA path.

Test Plan:
- Code read addr 8'h25, mem_ready one cycle after mem_select, mem_rdata 8'hA5 -> io_select stays 0, data_out=8'hA5, data_ready pulses at cycle 2.
- Data write addr 8'h30, data_in 8'h5C -> io_select=1, io_addr=8'h30, io_wdata=8'h5C; io_ready after 3 wait cycles gives data_ready at cycle 5, no mem_select.
- Data read at boundaries 8'h1F, 8'h20, 8'h5F, 8'h60 -> targets MEM, IO, IO, MEM respectively.
- select held high through RESP -> exactly one target access per data_ready; the new access starts only in the following IDLE cycle.
- With SPELL_MEM_ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, IO read never ready -> io_select drops, data_out=8'hFF, data_ready and bus_error high together at cycle 6. Ready coinciding with the timeout count -> no bus_error.
- rst_n pulled low during WAIT_MEM -> mem_select falls immediately and all outputs are 0. After release, the next select gives a normal 2-cycle access.
